// File: rtl/sa_cache_ctrl.sv
// Miss/replacement sequencer for a 4-way set-associative cache with tree PLRU.
// Define SA_CACHE_PERF_EN to build the saturating hit/miss counters.
module sa_cache_ctrl #(
  parameter int TAG_W = 18,
  parameter int IDX_W = 8,
  parameter int OFF_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  output logic             cpu_ready,
  input  logic [3:0]       hit_way,
  input  logic [3:0]       way_valid,
  input  logic [3:0]       way_dirty,
  input  logic [TAG_W-1:0] victim_tag,
  output logic [IDX_W-1:0] arr_idx,
  output logic [1:0]       sel_way,
  output logic             data_we,
  output logic             fill_we,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  input  logic             mem_ack,
  output logic [31:0]      hit_cnt,
  output logic [31:0]      miss_cnt
);

  typedef enum logic [1:0] {
    IDLE, LOOKUP, WRITEBACK, REFILL
  } state_t;

  state_t           state;
  logic             req_we;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [1:0]       vict_q;
  logic [31:0]      wb_addr;
  logic [2:0]       plru [2**IDX_W];

  logic       hit;
  logic [1:0] hit_enc;
  logic [1:0] inv_enc;
  logic [1:0] plru_vict;
  logic [1:0] miss_vict;
  logic [2:0] plru_cur;
  logic [2:0] plru_next;
  logic       unused_off;

  assign hit        = |hit_way;
  assign plru_cur   = plru[req_idx];
  assign unused_off = ^cpu_addr[OFF_W-1:0];

  // plru bits: [0]=b0 selects pair, [1]=b1 low pair, [2]=b2 high pair
  always_comb begin
    hit_enc = 2'd0;
    priority case (1'b1)
      hit_way[0]: hit_enc = 2'd0;
      hit_way[1]: hit_enc = 2'd1;
      hit_way[2]: hit_enc = 2'd2;
      hit_way[3]: hit_enc = 2'd3;
      default:    hit_enc = 2'd0;
    endcase
    inv_enc = 2'd0;
    priority case (1'b0)
      way_valid[0]: inv_enc = 2'd0;
      way_valid[1]: inv_enc = 2'd1;
      way_valid[2]: inv_enc = 2'd2;
      way_valid[3]: inv_enc = 2'd3;
      default:      inv_enc = 2'd0;
    endcase
    plru_vict = plru_cur[0] ? {1'b1, plru_cur[2]}
                            : {1'b0, plru_cur[1]};
    miss_vict = (&way_valid) ? plru_vict : inv_enc;
    if (hit_enc[1])
      plru_next = {~hit_enc[0], plru_cur[1], 1'b0};
    else
      plru_next = {plru_cur[2], ~hit_enc[0], 1'b1};
  end

  always_comb begin
    cpu_ready = 1'b0;
    data_we   = 1'b0;
    fill_we   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    sel_way   = 2'd0;
    arr_idx   = req_idx;
    unique case (state)
      IDLE: ;
      LOOKUP: begin
        if (hit) begin
          sel_way   = hit_enc;
          cpu_ready = 1'b1;
          data_we   = req_we;
        end else begin
          sel_way = miss_vict;
        end
      end
      WRITEBACK: begin
        sel_way  = vict_q;
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = wb_addr;
      end
      REFILL: begin
        sel_way  = vict_q;
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_idx, {OFF_W{1'b0}}};
        fill_we  = mem_ack;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      req_we  <= 1'b0;
      req_tag <= '0;
      req_idx <= '0;
      vict_q  <= 2'd0;
      wb_addr <= '0;
      for (int i = 0; i < 2**IDX_W; i++)
        plru[i] <= 3'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cpu_req) begin
            req_we  <= cpu_we;
            req_tag <= cpu_addr[OFF_W+IDX_W +: TAG_W];
            req_idx <= cpu_addr[OFF_W +: IDX_W];
            state   <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            plru[req_idx] <= plru_next;
            state         <= IDLE;
          end else begin
            vict_q  <= miss_vict;
            wb_addr <= {victim_tag, req_idx, {OFF_W{1'b0}}};
            if (way_valid[miss_vict] && way_dirty[miss_vict])
              state <= WRITEBACK;
            else
              state <= REFILL;
          end
        end
        WRITEBACK: if (mem_ack) state <= REFILL;
        REFILL:    if (mem_ack) state <= LOOKUP;
        default:   state <= IDLE;
      endcase
    end
  end

`ifdef SA_CACHE_PERF_EN
  // replay marks the post-refill lookup, which is not counted
  logic replay;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      replay   <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (state == IDLE)
        replay <= 1'b0;
      else if (state == REFILL && mem_ack)
        replay <= 1'b1;
      if (state == LOOKUP && !replay) begin
        if (hit) begin
          if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
        end else if (miss_cnt != '1) begin
          miss_cnt <= miss_cnt + 32'd1;
        end
      end
    end
  end
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_sa_cache_ctrl.sv
// Bench for sa_cache_ctrl: directed corner sequences, a hand-derived vector
// table and random accesses against a pair/recency model of the cache.
module tb_sa_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic        cpu_ready;
  logic [3:0]  hit_way, way_valid, way_dirty;
  logic [17:0] victim_tag;
  logic [7:0]  arr_idx;
  logic [1:0]  sel_way;
  logic        data_we, fill_we, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, hit_cnt, miss_cnt;

  sa_cache_ctrl dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_ready(cpu_ready), .hit_way(hit_way),
    .way_valid(way_valid), .way_dirty(way_dirty),
    .victim_tag(victim_tag), .arr_idx(arr_idx), .sel_way(sel_way),
    .data_we(data_we), .fill_we(fill_we), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  // directed drive vs. array/memory environment
  logic        env_on = 1'b0;
  logic [3:0]  d_hit = '0, d_val = '0, d_dirty = '0;
  logic [17:0] d_vtag = '0;
  logic        d_ack = 1'b0;
  logic        a_ack = 1'b0;
  logic [17:0] cur_tag = '0;
  int          wcnt = 0;

  logic [17:0] e_tag [256][4] = '{default: '{default: '0}};
  logic [3:0]  e_val [256] = '{default: '0};
  logic [3:0]  e_dirty [256] = '{default: '0};
  logic [3:0]  e_hit;

  always_comb begin
    e_hit = 4'b0;
    for (int w = 0; w < 4; w++)
      e_hit[w] = e_val[arr_idx][w] && (e_tag[arr_idx][w] == cur_tag);
    hit_way = env_on ? e_hit : d_hit;
  end

  assign way_valid  = env_on ? e_val[arr_idx] : d_val;
  assign way_dirty  = env_on ? e_dirty[arr_idx] : d_dirty;
  assign victim_tag = env_on ? e_tag[arr_idx][sel_way] : d_vtag;
  assign mem_ack    = env_on ? a_ack : d_ack;

  always @(negedge clk) begin
    if (env_on && fill_we) begin
      e_tag[arr_idx][sel_way]   = cur_tag;
      e_val[arr_idx][sel_way]   = 1'b1;
      e_dirty[arr_idx][sel_way] = 1'b0;
    end
    if (env_on && data_we)
      e_dirty[arr_idx][sel_way] = 1'b1;
  end

  // memory responder: random wait, one-cycle ack per transaction
  always @(posedge clk) begin
    #1;
    if (!env_on || !rst) a_ack = 1'b0;
    else if (a_ack) a_ack = 1'b0;
    else if (mem_req) begin
      if (wcnt == 0) begin
        a_ack = 1'b1;
        wcnt  = $urandom_range(0, 3);
      end else wcnt = wcnt - 1;
    end
  end

  // reference: per set, which pair was used last and which way inside each pair
  logic [17:0] m_tag [256][4] = '{default: '{default: '0}};
  logic [3:0]  m_val [256] = '{default: '0};
  logic [3:0]  m_dirty [256] = '{default: '0};
  logic        lo_recent [256] = '{default: 1'b0};
  logic [1:0]  last_lo [256] = '{default: 2'd1};
  logic [1:0]  last_hi [256] = '{default: 2'd3};
  int          m_hits = 0;
  int          m_miss = 0;

  typedef struct {
    logic        done;
    int          rd_cnt;
    logic [31:0] rd_addr;
    int          wb_cnt;
    logic [31:0] wb_addr;
    int          fill_cnt;
    logic [1:0]  fill_way;
    logic [1:0]  ready_way;
    logic        ready_dwe;
    int          lat;
  } obs_t;

  typedef struct {
    logic        we;
    logic [17:0] tag;
    logic        miss;
    logic        wb;
    logic [1:0]  way;
    logic [17:0] wb_tag;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic model_step(input logic we, input logic [17:0] tag,
                            input logic [7:0] idx, output logic miss,
                            output logic wb, output logic [1:0] way,
                            output logic [31:0] wba);
    miss = 1'b1; wb = 1'b0; way = 2'd0; wba = '0;
    for (int w = 3; w >= 0; w--)
      if (m_val[idx][w] && m_tag[idx][w] == tag) begin
        miss = 1'b0;
        way  = w[1:0];
      end
    if (miss) begin
      m_miss++;
      if (&m_val[idx])
        way = lo_recent[idx] ? ((last_hi[idx] == 2'd2) ? 2'd3 : 2'd2)
                             : ((last_lo[idx] == 2'd0) ? 2'd1 : 2'd0);
      else
        for (int w = 3; w >= 0; w--)
          if (!m_val[idx][w]) way = w[1:0];
      wb  = m_val[idx][way] && m_dirty[idx][way];
      wba = {m_tag[idx][way], idx, 6'd0};
      m_tag[idx][way]   = tag;
      m_val[idx][way]   = 1'b1;
      m_dirty[idx][way] = 1'b0;
    end else m_hits++;
    if (we) m_dirty[idx][way] = 1'b1;
    lo_recent[idx] = (way < 2'd2);
    if (way < 2'd2) last_lo[idx] = way;
    else last_hi[idx] = way;
  endtask

  task automatic access(input logic we, input logic [31:0] addr,
                        output obs_t o);
    o = '{default: 0};
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr;
    cur_tag = addr[31:14];
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (fill_we) begin
        o.fill_cnt = o.fill_cnt + 1;
        o.fill_way = sel_way;
      end
      if (mem_req && mem_ack) begin
        if (mem_we) begin
          o.wb_cnt = o.wb_cnt + 1; o.wb_addr = mem_addr;
        end else begin
          o.rd_cnt = o.rd_cnt + 1; o.rd_addr = mem_addr;
        end
      end
      if (cpu_ready) begin
        o.done = 1'b1; o.ready_way = sel_way;
        o.ready_dwe = data_we; o.lat = c;
        break;
      end
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic check_obs(input string nm, input obs_t o, input logic we,
                           input logic miss, input logic wb,
                           input logic [1:0] way, input logic [31:0] wba,
                           input logic [31:0] line);
    chk({nm, "_done"}, o.done, 1);
    chk({nm, "_rd"}, o.rd_cnt, {31'd0, miss});
    chk({nm, "_wb"}, o.wb_cnt, {31'd0, wb});
    if (wb) chk({nm, "_wbaddr"}, o.wb_addr, wba);
    if (miss) begin
      chk({nm, "_rdaddr"}, o.rd_addr, line);
      chk({nm, "_fills"}, o.fill_cnt, 1);
      chk({nm, "_fillway"}, o.fill_way, way);
      chk({nm, "_lat"}, o.lat >= (wb ? 4 : 3), 1);
    end else begin
      chk({nm, "_lat"}, o.lat, 1);
    end
    chk({nm, "_way"}, o.ready_way, way);
    chk({nm, "_dwe"}, o.ready_dwe, we);
  endtask

  task automatic hit_once(input logic [31:0] addr, input logic [3:0] h);
    cpu_req = 1'b1; cpu_addr = addr; d_hit = h;
    @(negedge clk);
    chk("hit_once_rdy", cpu_ready, 1);
    cpu_req = 1'b0;
    @(negedge clk);
    d_hit = 4'b0;
  endtask

  task automatic chk_reset_state();
    chk("rst_ready", cpu_ready, 0);
    chk("rst_dwe", data_we, 0);
    chk("rst_fwe", fill_we, 0);
    chk("rst_mreq", mem_req, 0);
    chk("rst_mwe", mem_we, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_idx", arr_idx, 0);
    chk("rst_sel", sel_way, 0);
    chk("rst_hcnt", hit_cnt, 0);
    chk("rst_mcnt", miss_cnt, 0);
  endtask

  initial begin
    obs_t        o;
    logic        miss, wb;
    logic [1:0]  way;
    logic [31:0] wba, addr;
    logic [17:0] tag;
    logic [7:0]  idx;
    logic        we;

    tbl[0] = '{1'b0, 18'd1, 1'b1, 1'b0, 2'd0, 18'd0};
    tbl[1] = '{1'b1, 18'd2, 1'b1, 1'b0, 2'd1, 18'd0};
    tbl[2] = '{1'b0, 18'd3, 1'b1, 1'b0, 2'd2, 18'd0};
    tbl[3] = '{1'b1, 18'd4, 1'b1, 1'b0, 2'd3, 18'd0};
    tbl[4] = '{1'b0, 18'd1, 1'b0, 1'b0, 2'd0, 18'd0};
    tbl[5] = '{1'b0, 18'd5, 1'b1, 1'b0, 2'd2, 18'd0};
    tbl[6] = '{1'b0, 18'd6, 1'b1, 1'b1, 2'd1, 18'd2};
    tbl[7] = '{1'b1, 18'd5, 1'b0, 1'b0, 2'd2, 18'd0};
    tbl[8] = '{1'b0, 18'd7, 1'b1, 1'b0, 2'd0, 18'd0};
    tbl[9] = '{1'b0, 18'd8, 1'b1, 1'b1, 2'd3, 18'd4};

    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_state();
    rst = 1'b1;
    @(negedge clk);

    // clean miss into an empty set
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_1040;
    @(negedge clk);
    chk("t1_lk_sel", sel_way, 0);
    chk("t1_lk_rdy", cpu_ready, 0);
    @(negedge clk);
    chk("t1_req", mem_req, 1);
    chk("t1_we", mem_we, 0);
    chk("t1_addr", mem_addr, 32'h0000_1040);
    chk("t1_idx", arr_idx, 8'h41);
    d_ack = 1'b1; #1;
    chk("t1_fill", fill_we, 1);
    chk("t1_fsel", sel_way, 0);
    @(negedge clk);
    d_ack = 1'b0; d_hit = 4'b0001; #1;
    chk("t1_rdy", cpu_ready, 1);
    chk("t1_fill_off", fill_we, 0);
    cpu_req = 1'b0;
    @(negedge clk);

    // load hit on way 2, then PLRU picks way 1 in that set
    cpu_req = 1'b1; d_hit = 4'b0100; d_val = 4'b0101;
    @(negedge clk);
    chk("t2_rdy", cpu_ready, 1);
    chk("t2_sel", sel_way, 2);
    chk("t2_mreq", mem_req, 0);
    cpu_req = 1'b0;
    @(negedge clk);
    chk("t2_rdy_pulse", cpu_ready, 0);
    cpu_req = 1'b1; d_hit = 4'b0; d_val = 4'hF; d_dirty = 4'h0;
    @(negedge clk);
    chk("t2_plru_vict", sel_way, 1);
    @(negedge clk);
    chk("t2_clean_we", mem_we, 0);
    chk("t2_clean_req", mem_req, 1);
    d_ack = 1'b1; #1;
    chk("t2_fsel", sel_way, 1);
    @(negedge clk);
    d_ack = 1'b0; d_hit = 4'b0010; #1;
    chk("t2_replay", cpu_ready, 1);
    cpu_req = 1'b0;
    @(negedge clk);
    d_hit = 4'b0;

    // dirty victim way 3 in set 5
    hit_once({18'h1, 8'h05, 6'h0}, 4'b0100);
    hit_once({18'h1, 8'h05, 6'h0}, 4'b0001);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = {18'h3, 8'h05, 6'h0};
    d_val = 4'hF; d_dirty = 4'hF; d_vtag = 18'h2AAAA;
    @(negedge clk);
    chk("t3_vict", sel_way, 3);
    @(negedge clk);
    chk("t3_wb_req", mem_req, 1);
    chk("t3_wb_we", mem_we, 1);
    chk("t3_wb_addr", mem_addr, 32'hAAAA_8140);
    d_ack = 1'b1;
    @(negedge clk);
    d_ack = 1'b0;
    chk("t3_rf_req", mem_req, 1);
    chk("t3_rf_we", mem_we, 0);
    chk("t3_rf_addr", mem_addr, 32'h0000_C140);
    cpu_we = 1'b1; cpu_addr = {18'h7, 8'h09, 6'h0};
    #1;
    chk("t4_idx_held", arr_idx, 8'h05);
    chk("t4_addr_held", mem_addr, 32'h0000_C140);
    @(negedge clk);
    chk("t3_wait_req", mem_req, 1);
    d_ack = 1'b1; #1;
    chk("t3_fill", fill_we, 1);
    chk("t3_fsel", sel_way, 3);
    @(negedge clk);
    d_ack = 1'b0; d_hit = 4'b1000; #1;
    chk("t3_rdy", cpu_ready, 1);
    chk("t3_load_dwe", data_we, 0);
    @(negedge clk);
    d_hit = 4'b0001; #1;
    chk("t4_idle_rdy", cpu_ready, 0);
    chk("t4_idle_req", mem_req, 0);
    @(negedge clk);
    chk("t4_st_rdy", cpu_ready, 1);
    chk("t4_st_dwe", data_we, 1);
    chk("t4_st_idx", arr_idx, 8'h09);
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    d_hit = 4'b0;
    chk("t4_dwe_pulse", data_we, 0);

    // async reset mid-refill, then a stray ack
    cpu_req = 1'b1; cpu_addr = 32'h0000_2080; d_val = 4'h0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_req_pre", mem_req, 1);
    rst = 1'b0; #1;
    chk("t5_req_drop", mem_req, 0);
    chk("t5_idx", arr_idx, 0);
    chk("t5_addr", mem_addr, 0);
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b1; d_ack = 1'b1; #1;
    chk("t5_stray_fill", fill_we, 0);
    @(negedge clk);
    d_ack = 1'b0;
    chk("t5_rdy", cpu_ready, 0);
    chk("t5_req", mem_req, 0);

    // environment-driven phase from a fresh reset
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state();
    env_on = 1'b1;

    for (int i = 0; i < 10; i++) begin
      addr = {tbl[i].tag, 8'h03, 6'h0};
      access(tbl[i].we, addr, o);
      model_step(tbl[i].we, tbl[i].tag, 8'h03, miss, wb, way, wba);
      check_obs($sformatf("v%0d", i), o, tbl[i].we, tbl[i].miss,
                tbl[i].wb, tbl[i].way, {tbl[i].wb_tag, 8'h03, 6'h0},
                addr);
    end

    for (int i = 0; i < 150; i++) begin
      tag  = 18'($urandom_range(0, 5));
      idx  = 8'($urandom_range(0, 3));
      we   = 1'($urandom_range(0, 1));
      addr = {tag, idx, 6'($urandom_range(0, 63))};
      access(we, addr, o);
      model_step(we, tag, idx, miss, wb, way, wba);
      check_obs($sformatf("r%0d", i), o, we, miss, wb, way, wba,
                {tag, idx, 6'h0});
    end

    @(negedge clk);
`ifdef SA_CACHE_PERF_EN
    chk("perf_hits", hit_cnt, m_hits);
    chk("perf_miss", miss_cnt, m_miss);
`else
    chk("perf_hits_off", hit_cnt, 0);
    chk("perf_miss_off", miss_cnt, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
